// File: rtl/ula_driver.sv
// ula_driver: sequences one operation at a time through a combinational ULA.
// A request is latched onto the ULA operand/select registers. The ULA outputs
// are given SETTLE cycles to settle, then captured. The captured result is
// held for a consumer handshake. Captures that have flag=1 are counted in a
// saturating 8-bit counter.
module ula_driver #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    // request side
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_sel,
    // ULA side
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [1:0]       sel,
    input  logic [WIDTH-1:0] resul,
    input  logic             flag,
    // response side
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_resul,
    output logic             rsp_flag,
    // flag statistics
    input  logic             clr_count,
    output logic [7:0]       flag_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // SETTLE is limited to 1..15, so a 4-bit down-counter always holds it.
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] rsp_resul_q, rsp_resul_d;
    logic             rsp_flag_q, rsp_flag_d;
    logic [7:0]       flag_count_q, flag_count_d;
    logic             capture;

    // Next-state logic: accept in IDLE, count down in WAIT, handshake in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        rsp_resul_d = rsp_resul_q;
        rsp_flag_d  = rsp_flag_q;
        capture     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    sel_d   = req_sel;
                    cnt_d   = SETTLE_CNT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A count of 1 or less marks the last settle cycle. The
                // "less" case covers a count of zero and prevents a hang there.
                if (cnt_q <= 4'd1) begin
                    capture     = 1'b1;
                    rsp_resul_d = resul;
                    rsp_flag_d  = flag;
                    cnt_d       = 4'd0;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Flag statistics: a saturating increment on flagged captures. A clear
    // takes priority over an increment on the same edge.
    always_comb begin
        flag_count_d = flag_count_q;
        if (capture && flag && (flag_count_q != 8'hFF)) begin
            flag_count_d = flag_count_q + 8'd1;
        end
        if (clr_count) begin
            flag_count_d = 8'd0;
        end
    end

    // State and datapath registers. Reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= 2'b00;
            rsp_resul_q  <= '0;
            rsp_flag_q   <= 1'b0;
            flag_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            rsp_resul_q  <= rsp_resul_d;
            rsp_flag_q   <= rsp_flag_d;
            flag_count_q <= flag_count_d;
        end
    end

    // req_ready is gated by rst so that it drops as soon as reset is asserted.
    always_comb begin
        req_ready = (state_q == S_IDLE) && !rst;
        rsp_valid = (state_q == S_RESP);
    end

    assign A          = a_q;
    assign B          = b_q;
    assign sel        = sel_q;
    assign rsp_resul  = rsp_resul_q;
    assign rsp_flag   = rsp_flag_q;
    assign flag_count = flag_count_q;

endmodule

// File: tb/tb_ula_driver.sv
// tb_ula_driver: directed self-checking bench for ula_driver.
// The main instance uses SETTLE=3. A second instance uses SETTLE=1 and
// checks the single-cycle latency and the first accept after reset.
module tb_ula_driver;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // main instance (SETTLE=3)
    logic         req_valid, req_ready, rsp_valid, rsp_ready, clr_count;
    logic [W-1:0] req_a, req_b, a_o, b_o, resul, rsp_resul;
    logic [1:0]   req_sel, sel_o;
    logic         flag, rsp_flag;
    logic [7:0]   flag_count;

    // second instance (SETTLE=1)
    logic         s1_req_valid, s1_req_ready, s1_rsp_valid, s1_rsp_ready, s1_clr_count;
    logic [W-1:0] s1_req_a, s1_req_b, s1_a_o, s1_b_o, s1_resul, s1_rsp_resul;
    logic [1:0]   s1_req_sel, s1_sel_o;
    logic         s1_flag, s1_rsp_flag;
    logic [7:0]   s1_flag_count;

    int total = 0;
    int bad   = 0;

    // ULA reference: sel 00 is add with carry out, sel 01 is subtract with borrow.
    function automatic logic [W:0] ula_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] s);
        logic [W:0] r;
        case (s)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} - {1'b0, b};
            default: r = {1'b0, a & b};
        endcase
        return r;
    endfunction

    assign {flag, resul}       = ula_model(a_o, b_o, sel_o);
    assign {s1_flag, s1_resul} = ula_model(s1_a_o, s1_b_o, s1_sel_o);

    ula_driver #(.WIDTH(W), .SETTLE(3)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .A(a_o), .B(b_o), .sel(sel_o),
        .resul(resul), .flag(flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_resul(rsp_resul), .rsp_flag(rsp_flag),
        .clr_count(clr_count), .flag_count(flag_count)
    );

    ula_driver #(.WIDTH(W), .SETTLE(1)) u_dut_s1 (
        .clk(clk), .rst(rst),
        .req_valid(s1_req_valid), .req_ready(s1_req_ready),
        .req_a(s1_req_a), .req_b(s1_req_b), .req_sel(s1_req_sel),
        .A(s1_a_o), .B(s1_b_o), .sel(s1_sel_o),
        .resul(s1_resul), .flag(s1_flag),
        .rsp_valid(s1_rsp_valid), .rsp_ready(s1_rsp_ready),
        .rsp_resul(s1_rsp_resul), .rsp_flag(s1_rsp_flag),
        .clr_count(s1_clr_count), .flag_count(s1_flag_count)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle. Returns at the negedge after the accept edge.
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sel   = s;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Count edges until rsp_valid is seen. Returns 0 if the bound expires.
    task automatic wait_resp(output int edges);
        edges = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int  e;
        bit  spurious;
        req_valid = 0; req_a = 0; req_b = 0; req_sel = 0; rsp_ready = 0; clr_count = 0;
        // The SETTLE=1 request is already valid during reset, so the first
        // edge after release must accept it.
        s1_req_valid = 1; s1_req_a = 4'hF; s1_req_b = 4'h1; s1_req_sel = 2'b00;
        s1_rsp_ready = 0; s1_clr_count = 0;

        // reset values
        #3;
        check_output("rst_req_ready", req_ready, 0);
        check_output("rst_s1_req_ready", s1_req_ready, 0);
        check_output("rst_A", a_o, 0);
        check_output("rst_rsp_valid", rsp_valid, 0);
        check_output("rst_flag_count", flag_count, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("idle_req_ready", req_ready, 1);

        // SETTLE=1: 1111+0001 gives 0000 with carry, one edge after accept
        @(negedge clk);
        check_output("s1_first_accept_A", s1_a_o, 4'hF);
        check_output("s1_valid_early", s1_rsp_valid, 0);
        s1_req_valid = 1'b0;
        @(negedge clk);
        check_output("s1_rsp_valid", s1_rsp_valid, 1);
        check_output("s1_rsp_resul", s1_rsp_resul, 4'h0);
        check_output("s1_rsp_flag", s1_rsp_flag, 1);
        check_output("s1_flag_count", s1_flag_count, 1);
        s1_rsp_ready = 1'b1;
        @(negedge clk);
        s1_rsp_ready = 1'b0;
        check_output("s1_back_idle", s1_req_ready, 1);

        // SETTLE=3: 0111-0110 gives 0001 with no borrow
        apply_stimulus(4'h7, 4'h6, 2'b01);
        check_output("wait_valid", rsp_valid, 0);
        check_output("wait_req_ready", req_ready, 0);
        wait_resp(e);
        check_output("latency3", e, 3);
        check_output("sub_resul", rsp_resul, 4'h1);
        check_output("sub_flag", rsp_flag, 0);
        check_output("hold_A", a_o, 4'h7);
        check_output("hold_B", b_o, 4'h6);
        check_output("hold_sel", sel_o, 2'b01);

        // Hold off rsp_ready. Request pulses arriving now must be ignored.
        for (int i = 0; i < 5; i++) begin
            req_valid = i[0];
            req_a = 4'h3; req_b = 4'h3; req_sel = 2'b00;
            @(negedge clk);
            check_output("stall_valid", rsp_valid, 1);
            check_output("stall_resul", rsp_resul, 4'h1);
            check_output("stall_req_ready", req_ready, 0);
            check_output("stall_A", a_o, 4'h7);
        end
        // The handshake edge must not also accept a new request.
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check_output("hs_valid", rsp_valid, 0);
        check_output("hs_req_ready", req_ready, 1);
        check_output("hs_no_accept_A", a_o, 4'h7);
        check_output("hs_hold_resul", rsp_resul, 4'h1);

        // 256 carry-producing operations; the counter saturates at 255.
        for (int i = 1; i <= 256; i++) begin
            apply_stimulus(4'hF, 4'h1, 2'b00);
            wait_resp(e);
            if (e != 3) check_output("carry_latency", e, 3);
            if (i == 1) begin
                check_output("carry_resul", rsp_resul, 4'h0);
                check_output("carry_flag", rsp_flag, 1);
                check_output("count_1", flag_count, 1);
            end
            if (i == 255) check_output("count_255", flag_count, 255);
            if (i == 256) check_output("count_sat", flag_count, 255);
            handshake();
        end

        // Clear asserted across a flagged capture: the clear wins.
        clr_count = 1'b1;
        apply_stimulus(4'hF, 4'h1, 2'b00);
        wait_resp(e);
        check_output("clr_latency", e, 3);
        check_output("clr_wins", flag_count, 0);
        clr_count = 1'b0;
        handshake();
        apply_stimulus(4'hF, 4'h1, 2'b00);
        wait_resp(e);
        check_output("count_after_clr", flag_count, 1);
        handshake();

        // Reset between edges during WAIT abandons the operation.
        apply_stimulus(4'h9, 4'h3, 2'b00);
        #2 rst = 1'b1;
        #1;
        check_output("mid_rst_A", a_o, 0);
        check_output("mid_rst_B", b_o, 0);
        check_output("mid_rst_req_ready", req_ready, 0);
        check_output("mid_rst_rsp_flag", rsp_flag, 0);
        check_output("mid_rst_count", flag_count, 0);
        @(negedge clk);
        rst = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) spurious = 1'b1;
        end
        check_output("no_rsp_after_rst", spurious, 0);

        // The next request after reset completes normally: 0010-0101 = 1101 with borrow.
        apply_stimulus(4'h2, 4'h5, 2'b01);
        wait_resp(e);
        check_output("post_rst_latency", e, 3);
        check_output("post_rst_resul", rsp_resul, 4'hD);
        check_output("post_rst_flag", rsp_flag, 1);
        check_output("post_rst_count", flag_count, 1);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ula_driver.md
ULA_DRIVER -- requirements
Module: ula_driver

Interface
REQ-001 Parameter: WIDTH, 4, operand/result width matching the team ULA.
REQ-002 Parameter: SETTLE, 1, cycles the ULA outputs are held before sampling; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  operation request present.
REQ-006 req_ready  out  1  driver can accept a request.
REQ-007 req_a, req_b  in  WIDTH  operands.
REQ-008 req_sel  in  2  ULA operation select, passed through unmodified.
REQ-009 A, B  out  WIDTH  registered operands to the ULA instance.
REQ-010 sel  out  2  registered select to the ULA instance.
REQ-011 resul  in  WIDTH  ULA result.
REQ-012 flag  in  1  ULA flag.
REQ-013 rsp_valid  out  1  captured result available.
REQ-014 rsp_ready  in  1  consumer accepts the result.
REQ-015 rsp_resul  out  WIDTH  captured result; rsp_flag  out  1  captured flag.
REQ-016 clr_count  in  1  synchronous clear of flag_count.
REQ-017 flag_count  out  8  number of captured results with flag=1, saturating.

Function
REQ-018 FSM states: IDLE, WAIT, RESP; no other reachable state.
REQ-019 req_ready SHALL be 1 exactly when state=IDLE and rst=0 (combinational).
REQ-020 Request accept = req_valid & req_ready at a rising edge; on that edge A/B/sel load req_a/req_b/req_sel, settle counter loads SETTLE, state -> WAIT.
REQ-021 In WAIT: each edge decrements the counter; the edge on which counter=1 captures resul/flag into rsp_resul/rsp_flag, state -> RESP.
REQ-022 Latency: result captured SETTLE edges after the accept edge; rsp_valid high from that edge.
REQ-023 rsp_valid SHALL be 1 exactly in RESP; rsp_resul/rsp_flag stable while rsp_valid=1.
REQ-024 rsp_valid & rsp_ready at an edge -> IDLE; req_ready high the following cycle; no accept on the same edge.
REQ-025 rsp_ready while not in RESP is ignored; req_valid while not in IDLE is ignored (not queued).
REQ-026 A/B/sel SHALL change only on an accept edge and hold last values otherwise.
REQ-027 rsp_resul/rsp_flag SHALL hold last captured values after handshake until next capture.
REQ-028 flag_count increments by 1 on a capture edge with flag=1; holds at 255.
REQ-029 clr_count=1 sets flag_count to 0 at the edge; clear wins over simultaneous increment.
REQ-030 Inputs resul/flag SHALL be sampled only on the capture edge; changes at other times have no effect.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, A=B=0, sel=0, rsp_valid=0, rsp_resul=0, rsp_flag=0, flag_count=0, counter=0, req_ready=0.
REQ-032 rst asserted mid-WAIT or mid-RESP abandons the operation; no response is produced.
REQ-033 First accept possible on the first rising edge with rst=0.

Verification (bench ULA model: sel=00 -> resul=A+B mod 16, flag=carry; sel=01 -> resul=A-B mod 16, flag=borrow)
REQ-034 SETTLE=1, accept a=1111 b=0001 sel=00 at edge 0 -> rsp_valid at edge 1, rsp_resul=0000, rsp_flag=1, flag_count=1.
REQ-035 SETTLE=3, accept a=0111 b=0110 sel=01 -> rsp_valid exactly 3 edges later, rsp_resul=0001, rsp_flag=0; A/B/sel held 0111/0110/01 throughout.
REQ-036 rsp_ready=0 for 5 cycles in RESP -> rsp_valid and outputs stable, req_ready=0, req_valid pulses ignored; rsp_ready=1 -> IDLE next cycle.
REQ-037 256 carry-producing ops -> flag_count=255; clr_count asserted with a flag=1 capture -> flag_count=0.
REQ-038 rst asserted between clock edges during WAIT -> outputs zero immediately, no rsp_valid after release, next request completes normally.
